// File: rtl/boreal_ledger_if.sv
// Bundles the ledger append, read-back and audit signals of boreal_ledger.
// The master side is the gate/host; the slave side is the ledger itself.
interface boreal_ledger_if;
   logic         ledger_wr_en;
   logic [255:0] ledger_wr_data;
   logic [31:0]  ledger_idx;
   logic [31:0]  chain_hash;
   logic         ledger_full;
   logic         ledger_overflow;
   logic [15:0]  drop_count;
   logic         rd_req;
   logic [31:0]  rd_addr;
   logic         rd_ready;
   logic         rd_valid;
   logic [255:0] rd_data;
   logic         rd_err;
   logic         audit_start;
   logic         audit_busy;
   logic         audit_done;
   logic         audit_ok;

   modport master (
      output ledger_wr_en, ledger_wr_data, rd_req, rd_addr, audit_start,
      input  ledger_idx, chain_hash, ledger_full, ledger_overflow, drop_count,
      input  rd_ready, rd_valid, rd_data, rd_err, audit_busy, audit_done, audit_ok
   );

   modport slave (
      input  ledger_wr_en, ledger_wr_data, rd_req, rd_addr, audit_start,
      output ledger_idx, chain_hash, ledger_full, ledger_overflow, drop_count,
      output rd_ready, rd_valid, rd_data, rd_err, audit_busy, audit_done, audit_ok
   );
endinterface

// File: rtl/boreal_ledger.sv
// Append-only 256-bit audit ledger with a running chain hash, a pipelined
// read-back port and a self-audit engine that replays the stored chain.
module boreal_ledger #(
   parameter int DEPTH = 64,
   parameter int AW    = 6
) (
   input logic            clk,
   input logic            rst,
   boreal_ledger_if.slave bus
);

   typedef enum logic [1:0] {A_IDLE, A_READ, A_ACC, A_CMP} audit_state_t;

   localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);
   localparam logic [AW:0] ONE        = (AW+1)'(1);

   logic [255:0] mem [DEPTH];
   logic [AW:0]  count;
   logic [31:0]  chain;
   logic         overflow;
   logic [15:0]  drops;
   logic         full;

   logic         rd_valid_q;
   logic         rd_err_q;
   logic [255:0] rd_data_q;
   logic         rd_accept;

   audit_state_t state;
   audit_state_t state_next;
   logic [AW:0]  snap_n;
   logic [AW:0]  idx;
   logic [31:0]  snap_s;
   logic [31:0]  acc;
   logic [255:0] entry_q;
   logic         done_q;
   logic         done_next;
   logic         ok_q;

   function automatic logic [31:0] rotl5(input logic [31:0] x);
      return {x[26:0], x[31:27]};
   endfunction

   function automatic logic [31:0] fold(input logic [255:0] d);
      logic [31:0] r;
      r = '0;
      for (int k = 0; k < 8; k++) r ^= d[32*k +: 32];
      return r;
   endfunction

   assign full      = (count == FULL_COUNT);
   assign rd_accept = bus.rd_req && (state == A_IDLE);

   assign bus.ledger_idx      = 32'(count);
   assign bus.chain_hash      = chain;
   assign bus.ledger_full     = full;
   assign bus.ledger_overflow = overflow;
   assign bus.drop_count      = drops;
   assign bus.rd_ready        = (state == A_IDLE);
   assign bus.rd_valid        = rd_valid_q;
   assign bus.rd_data         = rd_data_q;
   assign bus.rd_err          = rd_err_q;
   assign bus.audit_busy      = (state != A_IDLE);
   assign bus.audit_done      = done_q;
   assign bus.audit_ok        = ok_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         count    <= '0;
         chain    <= '0;
         overflow <= 1'b0;
         drops    <= '0;
      end else if (bus.ledger_wr_en) begin
         if (!full) begin
            count <= count + ONE;
            chain <= rotl5(chain) ^ fold(bus.ledger_wr_data);
         end else begin
            overflow <= 1'b1;
            if (drops != 16'hFFFF) drops <= drops + 16'd1;
         end
      end
   end

   // Storage is deliberately not reset; a zero count makes old entries unreachable.
   always_ff @(posedge clk) begin
      if (!rst && bus.ledger_wr_en && !full) mem[count[AW-1:0]] <= bus.ledger_wr_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_valid_q <= 1'b0;
         rd_err_q   <= 1'b0;
         rd_data_q  <= '0;
      end else begin
         rd_valid_q <= rd_accept;
         if (rd_accept) begin
            if (bus.rd_addr < 32'(count)) begin
               rd_err_q  <= 1'b0;
               rd_data_q <= mem[bus.rd_addr[AW-1:0]];
            end else begin
               rd_err_q  <= 1'b1;
               rd_data_q <= '0;
            end
         end
      end
   end

   always_comb begin
      state_next = state;
      done_next  = 1'b0;
      case (state)
         A_IDLE: if (bus.audit_start) state_next = (count != '0) ? A_READ : A_CMP;
         A_READ: state_next = A_ACC;
         A_ACC:  state_next = (idx == snap_n - ONE) ? A_CMP : A_READ;
         A_CMP: begin
            state_next = A_IDLE;
            done_next  = 1'b1;
         end
         default: state_next = A_IDLE;
      endcase
   end

   // The audit replays a frozen snapshot, so live appends never disturb it.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= A_IDLE;
         snap_n  <= '0;
         snap_s  <= '0;
         idx     <= '0;
         acc     <= '0;
         entry_q <= '0;
         done_q  <= 1'b0;
         ok_q    <= 1'b0;
      end else begin
         state  <= state_next;
         done_q <= done_next;
         case (state)
            A_IDLE: if (bus.audit_start) begin
               snap_n <= count;
               snap_s <= chain;
               acc    <= '0;
               idx    <= '0;
               ok_q   <= 1'b0;
            end
            A_READ: entry_q <= mem[idx[AW-1:0]];
            A_ACC: begin
               acc <= rotl5(acc) ^ fold(entry_q);
               idx <= idx + ONE;
            end
            A_CMP: ok_q <= (acc == snap_s);
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_boreal_ledger.sv
// Directed bench for boreal_ledger with a read scoreboard and a reference
// model of the count, chain hash and drop counter.
module tb_boreal_ledger;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   boreal_ledger_if bus();

   boreal_ledger #(.DEPTH(64), .AW(6)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic         err;
      logic [255:0] data;
      int           cyc;
   } rd_exp_t;

   int checks = 0;
   int passes = 0;
   int cyc = 0;
   rd_exp_t sb[$];
   rd_exp_t got;

   logic [255:0] mdl_mem [64];
   int           mdl_cnt = 0;
   logic [31:0]  mdl_chain = '0;
   int           mdl_drops = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string tag, input logic [255:0] observed, input logic [255:0] expected);
      checks++;
      assert (observed === expected) passes++;
      else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
   endtask

   function automatic logic [31:0] tbFold(input logic [255:0] d);
      logic [31:0] r = 32'h0;
      for (int w = 7; w >= 0; w--) r = r ^ d[w*32 +: 32];
      return r;
   endfunction

   function automatic logic [255:0] randEntry();
      logic [255:0] d;
      for (int w = 0; w < 8; w++) d[w*32 +: 32] = $urandom;
      return d;
   endfunction

   task automatic modelAppend(input logic [255:0] d);
      if (mdl_cnt < 64) begin
         mdl_mem[mdl_cnt] = d;
         mdl_chain = {mdl_chain[26:0], mdl_chain[31:27]} ^ tbFold(d);
         mdl_cnt++;
      end else if (mdl_drops < 65535) begin
         mdl_drops++;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic doReset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      mdl_cnt = 0;
      mdl_chain = '0;
      mdl_drops = 0;
   endtask

   // One append per call; the gate samples ledger_idx while its strobe is high.
   task automatic applyStimulus(input logic [255:0] d);
      bus.ledger_wr_en = 1'b1;
      bus.ledger_wr_data = d;
      checkOutput("idx_during_append", bus.ledger_idx, 256'(mdl_cnt));
      modelAppend(d);
      tick();
      bus.ledger_wr_en = 1'b0;
   endtask

   task automatic readEntry(input int addr);
      rd_exp_t e;
      bus.rd_req = 1'b1;
      bus.rd_addr = addr;
      e.err = (addr >= mdl_cnt);
      e.data = e.err ? '0 : mdl_mem[addr];
      e.cyc = cyc + 1;
      sb.push_back(e);
      tick();
      bus.rd_req = 1'b0;
   endtask

   task automatic checkResetOutputs(input string tag);
      checkOutput(tag, {bus.ledger_idx, bus.chain_hash, bus.ledger_full, bus.ledger_overflow,
                        bus.drop_count, bus.rd_valid, bus.rd_err, bus.audit_busy,
                        bus.audit_done, bus.audit_ok}, '0);
      checkOutput({tag, "_rd_data"}, bus.rd_data, '0);
   endtask

   task automatic runAudit(input string tag, input int n, input bit hold_start, input bit disturb);
      int t0 = cyc;
      int pulses = 0;
      int done_cyc = -1;
      logic ok_seen = 1'b0;
      bus.audit_start = 1'b1;
      for (int k = 0; k < 2*n + 12; k++) begin
         tick();
         bus.audit_start = hold_start && (cyc == t0 + 1);
         bus.ledger_wr_en = 1'b0;
         bus.rd_req = 1'b0;
         if (disturb && cyc == t0 + 3) begin
            bus.ledger_wr_en = 1'b1;
            bus.ledger_wr_data = randEntry();
            modelAppend(bus.ledger_wr_data);
         end
         if (disturb && cyc == t0 + 4) begin
            bus.rd_req = 1'b1;
            bus.rd_addr = 0;
         end
         if (bus.audit_done) begin
            pulses++;
            done_cyc = cyc;
            ok_seen = bus.audit_ok;
         end
         if (cyc < t0 + 2*n + 2) begin
            checkOutput({tag, "_busy"}, bus.audit_busy, 1);
            checkOutput({tag, "_rd_ready"}, bus.rd_ready, 0);
         end
      end
      bus.ledger_wr_en = 1'b0;
      bus.rd_req = 1'b0;
      checkOutput({tag, "_pulses"}, pulses, 1);
      checkOutput({tag, "_done_cycle"}, done_cyc - t0, 2*n + 2);
      checkOutput({tag, "_ok"}, ok_seen, 1);
   endtask

   // Scoreboard: every rd_valid must match the oldest outstanding request.
   always @(negedge clk) begin
      if (!rst && bus.rd_valid) begin
         if (sb.size() == 0) begin
            checkOutput("rd_unexpected_valid", bus.rd_valid, 0);
         end else begin
            got = sb.pop_front();
            checkOutput("rd_err", bus.rd_err, got.err);
            checkOutput("rd_data", bus.rd_data, got.data);
            checkOutput("rd_cycle", cyc, got.cyc);
         end
      end
   end

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      int t0;
      int pulses;
      logic [31:0] chain64;
      logic [255:0] e1;

      bus.ledger_wr_en = 1'b0;
      bus.ledger_wr_data = '0;
      bus.rd_req = 1'b0;
      bus.rd_addr = '0;
      bus.audit_start = 1'b0;

      $display("[TB] reset");
      doReset();
      checkResetOutputs("reset_outputs");
      checkOutput("reset_rd_ready", bus.rd_ready, 1);

      $display("[TB] two appends and read-back");
      e1 = 256'd1;
      applyStimulus(e1);
      applyStimulus(e1);
      checkOutput("idx_after_two", bus.ledger_idx, 2);
      checkOutput("chain_after_two", bus.chain_hash, 32'h00000021);
      checkOutput("chain_model_two", bus.chain_hash, mdl_chain);
      readEntry(0);
      tick();

      $display("[TB] out-of-range and back-to-back reads");
      readEntry(5);
      tick();
      readEntry(0);
      readEntry(1);
      tick();
      tick();

      $display("[TB] fill past capacity");
      doReset();
      chain64 = '0;
      for (int i = 0; i < 70; i++) begin
         applyStimulus(randEntry());
         if (i == 63) chain64 = mdl_chain;
      end
      checkOutput("full", bus.ledger_full, 1);
      checkOutput("idx_full", bus.ledger_idx, 64);
      checkOutput("overflow", bus.ledger_overflow, 1);
      checkOutput("drop_count", bus.drop_count, 16'd6);
      checkOutput("drop_model", bus.drop_count, 16'(mdl_drops));
      checkOutput("chain_frozen", bus.chain_hash, chain64);
      readEntry(63);
      readEntry(64);
      tick();
      tick();

      $display("[TB] audit of three entries with a concurrent append");
      doReset();
      for (int i = 0; i < 3; i++) applyStimulus(randEntry());
      runAudit("audit3", 3, 1'b0, 1'b1);
      checkOutput("idx_after_audit", bus.ledger_idx, 4);
      checkOutput("chain_after_audit", bus.chain_hash, mdl_chain);
      checkOutput("ok_held", bus.audit_ok, 1);
      readEntry(3);
      tick();
      tick();

      $display("[TB] empty audit with a repeated start");
      doReset();
      runAudit("audit0", 0, 1'b1, 1'b0);

      $display("[TB] reset during accumulate");
      doReset();
      for (int i = 0; i < 3; i++) applyStimulus(randEntry());
      t0 = cyc;
      bus.audit_start = 1'b1;
      tick();
      bus.audit_start = 1'b0;
      tick();
      checkOutput("in_acc_busy", bus.audit_busy, 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      mdl_cnt = 0;
      mdl_chain = '0;
      mdl_drops = 0;
      checkResetOutputs("midaudit_reset");
      pulses = 0;
      for (int k = 0; k < 10; k++) begin
         if (bus.audit_done) pulses++;
         tick();
      end
      checkOutput("no_done_after_reset", pulses, 0);
      e1 = randEntry();
      applyStimulus(e1);
      checkOutput("idx_after_reset_append", bus.ledger_idx, 1);
      checkOutput("chain_after_reset_append", bus.chain_hash, mdl_chain);
      readEntry(0);
      for (int k = 0; k < 4; k++) tick();
      checkOutput("scoreboard_drained", sb.size(), 0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
